async_fifo_rd_ctrl: RTL and testbench
=====================================

Name: async_fifo_rd_ctrl

Overview:
Next-generation read-side pointer and flag controller for the dual-clock FIFO, running entirely in the read domain. It takes the raw Gray write pointer from the write domain and synchronises it internally. It then produces the RAM read address, the Gray read pointer for the write side, and registered empty and almost-empty flags. It also provides a fill-level count, a read-data-valid strobe matched to synchronous-read RAM latency, and a sticky underflow error flag.

Parameters:
ADDR_W, 3, RAM address width; depth DEPTH = 2^ADDR_W; pointers are ADDR_W+1 bits.
SYNC_STAGES, 2, flops in the write-pointer synchroniser; legal range 2..4.

Ports:
R_CLK  input  1  read-domain clock; all state updates on the rising edge.
R_RST  input  1  synchronous reset, active-low; sampled on the R_CLK rising edge.
R_INC  input  1  read request; a pop occurs only when R_INC=1 and R_EMPTY=0.
G_wptr  input  ADDR_W+1  Gray write pointer, asynchronous to R_CLK.
AE_THRESH  input  ADDR_W+1  almost-empty threshold, quasi-static.
UF_CLR  input  1  clears R_UNDERFLOW.
G_rptr  output  ADDR_W+1  registered Gray read pointer, sent to the write domain.
R_addr  output  ADDR_W  binary RAM read address, equal to rbin[ADDR_W-1:0].
R_EMPTY  output  1  registered empty flag.
R_AEMPTY  output  1  registered almost-empty flag; 1 when level <= AE_THRESH.
R_LEVEL  output  ADDR_W+1  registered occupancy, range 0..DEPTH.
R_VALID  output  1  read data valid; pulses 1 cycle after each pop.
R_UNDERFLOW  output  1  sticky flag; set when R_INC=1 while R_EMPTY=1.

Behaviour:
- Reset (edge with R_RST=0):
  - Sync chain, rbin and G_rptr all reset to 0.
  - R_EMPTY=1, R_AEMPTY=1, R_LEVEL=0, R_VALID=0, R_UNDERFLOW=0.
  - Reset takes priority over every other input. Mid-operation reset discards all state, including the synchronised write pointer.
- Synchroniser: SYNC_STAGES flops on G_wptr; wsync is the last stage.
- pop = R_INC & ~R_EMPTY. When pop=1, rbin_nxt = rbin+1 modulo 2^(ADDR_W+1); otherwise rbin_nxt = rbin.
- G_rptr <= bin2gray(rbin_nxt), so after every edge G_rptr == bin2gray(rbin). There is no extra lag.
- All flags are registered, computed from next-state values (wsync_nxt, rbin_nxt):
  - lvl = gray2bin(wsync_nxt) - rbin_nxt, modulo 2^(ADDR_W+1).
  - R_EMPTY <= (bin2gray(rbin_nxt) == wsync_nxt).
  - R_LEVEL <= lvl.
  - R_AEMPTY <= (lvl <= AE_THRESH).
- Latency: a stable G_wptr change is reflected in R_EMPTY, R_LEVEL and R_AEMPTY exactly SYNC_STAGES edges later. A pop is reflected in R_addr, G_rptr and the flags on the same edge.
- Wrap: rbin wraps from 2^(ADDR_W+1)-1 to 0. R_addr wraps every DEPTH pops. Level arithmetic stays correct across the wrap.
- Full-domain case: level = DEPTH is legal. Then R_EMPTY=0 and the MSB pair of the Gray pointers differs.
- R_VALID <= pop. It pairs with RAM data read at the R_addr that was presented during the pop cycle.
- Underflow:
  - R_INC=1 with R_EMPTY=1 sets R_UNDERFLOW, and rbin does not change.
  - UF_CLR=1 clears R_UNDERFLOW on the next edge.
  - If set and clear occur on the same edge, set wins.
- AE_THRESH changes take effect at the next flag update.

Decomposition:
- Package fifo_pkg holds:
  - functions bin2gray and gray2bin, width-generic over ADDR_W+1;
  - default constants for ADDR_W and SYNC_STAGES.
- One sub-module, gray_ptr_sync (width ADDR_W+1, SYNC_STAGES deep, synchronous active-low reset). The write-side successor will reuse it.

Test Plan (ADDR_W=3, SYNC_STAGES=2, AE_THRESH=2 unless stated):
1. Reset: hold G_wptr=4'b0111 with R_RST=0 for 2 edges -> G_rptr=0, R_addr=0, R_EMPTY=1, R_AEMPTY=1, R_LEVEL=0, R_VALID=0, R_UNDERFLOW=0.
2. Sync latency: release reset, then drive G_wptr=gray(3)=4'b0010 -> after 1 edge R_EMPTY is still 1; after 2 edges R_EMPTY=0, R_LEVEL=3, R_AEMPTY=0.
3. Drain and underflow: hold R_INC=1 from level 3 -> the following must all hold:
   - R_addr steps 0,1,2,3 on successive edges;
   - R_LEVEL steps 3,2,1,0;
   - R_AEMPTY=1 from level 2;
   - R_EMPTY=1 after the 3rd pop;
   - R_VALID is high 3 cycles;
   - on the 4th request R_UNDERFLOW=1, R_addr stays 3, and R_VALID=0.
4. Full and wrap: with rbin=0, drive G_wptr=gray(8)=4'b1100 -> R_LEVEL=8 and R_EMPTY=0. After 8 pops: R_addr=0, G_rptr=4'b1100, R_EMPTY=1. Repeat to binary 16 -> G_rptr=0 and R_LEVEL stays correct.
5. Underflow clear: assert UF_CLR together with R_INC while empty -> R_UNDERFLOW stays 1. Then UF_CLR alone -> R_UNDERFLOW=0 on the next edge.
6. Mid-operation reset: at R_LEVEL=5, pulse R_RST=0 for 1 edge with G_wptr held -> all outputs at reset values. R_LEVEL then returns to the count implied by the held G_wptr (rbin now 0) 2 edges after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the dual-clock FIFO pointer controllers.
package fifo_pkg;

    localparam int ADDR_W_DEF      = 3;
    localparam int SYNC_STAGES_DEF = 2;
    // Helpers run at a fixed wide width; callers zero-extend and truncate to their pointer width.
    localparam int GW = 32;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module gray_ptr_sync
    import fifo_pkg::*;
#(
    parameter int W      = ADDR_W_DEF + 1,
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] sync_o
);

    logic [W-1:0] stage_q [STAGES];

    // Shift chain; synchronous active-low reset clears every stage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= ptr_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer/flag controller: read address, Gray read pointer, empty/almost-empty,
// fill level, read-valid strobe and sticky underflow, all in the read clock domain.
module async_fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              R_CLK,
    input  logic              R_RST,
    input  logic              R_INC,
    input  logic [ADDR_W:0]   G_wptr,
    input  logic [ADDR_W:0]   AE_THRESH,
    input  logic              UF_CLR,
    output logic [ADDR_W:0]   G_rptr,
    output logic [ADDR_W-1:0] R_addr,
    output logic              R_EMPTY,
    output logic              R_AEMPTY,
    output logic [ADDR_W:0]   R_LEVEL,
    output logic              R_VALID,
    output logic              R_UNDERFLOW
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wsync_nxt_s;
    logic [PTR_W-1:0] rbin_q, rbin_d;
    logic [PTR_W-1:0] grptr_q, grptr_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             empty_q, empty_d;
    logic             aempty_q, aempty_d;
    logic             valid_q, valid_d;
    logic             uf_q, uf_d;
    logic             pop_s;

    // The flag/level registers below act as the final synchroniser stage: they are computed
    // from the value that stage would capture, so the chain here is one flop shorter.
    gray_ptr_sync #(
        .W      (PTR_W),
        .STAGES (SYNC_STAGES - 1)
    ) u_wptr_sync (
        .clk_i  (R_CLK),
        .rst_ni (R_RST),
        .ptr_i  (G_wptr),
        .sync_o (wsync_nxt_s)
    );

    assign pop_s = R_INC & ~empty_q;

    // Next-state pointer, flags and level from next-state write and read pointers.
    always_comb begin
        rbin_d   = rbin_q;
        uf_d     = uf_q;
        if (pop_s) begin
            rbin_d = rbin_q + PTR_W'(1);
        end else begin
            rbin_d = rbin_q;
        end
        grptr_d  = PTR_W'(bin2gray(GW'(rbin_d)));
        level_d  = PTR_W'(gray2bin(GW'(wsync_nxt_s))) - rbin_d;
        empty_d  = (grptr_d == wsync_nxt_s);
        aempty_d = (level_d <= AE_THRESH);
        valid_d  = pop_s;
        // A new underflow on the same edge as a clear keeps the flag set.
        if (R_INC && empty_q) begin
            uf_d = 1'b1;
        end else if (UF_CLR) begin
            uf_d = 1'b0;
        end else begin
            uf_d = uf_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge R_CLK) begin
        if (!R_RST) begin
            rbin_q   <= '0;
            grptr_q  <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            valid_q  <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            grptr_q  <= grptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            valid_q  <= valid_d;
            uf_q     <= uf_d;
        end
    end

    assign G_rptr      = grptr_q;
    assign R_addr      = rbin_q[ADDR_W-1:0];
    assign R_EMPTY     = empty_q;
    assign R_AEMPTY    = aempty_q;
    assign R_LEVEL     = level_q;
    assign R_VALID     = valid_q;
    assign R_UNDERFLOW = uf_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed self-checking bench for async_fifo_rd_ctrl (ADDR_W=3, SYNC_STAGES=2).
module tb_async_fifo_rd_ctrl;

    logic       R_CLK = 1'b0;
    logic       R_RST, R_INC, UF_CLR;
    logic [3:0] G_wptr, AE_THRESH;
    logic [3:0] G_rptr;
    logic [2:0] R_addr;
    logic       R_EMPTY, R_AEMPTY, R_VALID, R_UNDERFLOW;
    logic [3:0] R_LEVEL;

    int vec_cnt = 0;
    int err_cnt = 0;

    async_fifo_rd_ctrl #(.ADDR_W(3), .SYNC_STAGES(2)) dut (
        .R_CLK(R_CLK), .R_RST(R_RST), .R_INC(R_INC), .G_wptr(G_wptr),
        .AE_THRESH(AE_THRESH), .UF_CLR(UF_CLR), .G_rptr(G_rptr), .R_addr(R_addr),
        .R_EMPTY(R_EMPTY), .R_AEMPTY(R_AEMPTY), .R_LEVEL(R_LEVEL),
        .R_VALID(R_VALID), .R_UNDERFLOW(R_UNDERFLOW)
    );

    always #5 R_CLK = ~R_CLK;

    task automatic tick();
        @(posedge R_CLK);
        #1;
    endtask

    task automatic test_reset();
        R_RST = 1'b0; R_INC = 1'b0; UF_CLR = 1'b0; AE_THRESH = 4'd2; G_wptr = 4'b0111;
        tick(); tick();
        vec_cnt++;
        if ({G_rptr, R_addr, R_EMPTY, R_AEMPTY, R_LEVEL, R_VALID, R_UNDERFLOW} !== {4'd0, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset: rptr=%b addr=%0d e=%b ae=%b lvl=%0d v=%b uf=%b, want 0 0 1 1 0 0 0",
                     G_rptr, R_addr, R_EMPTY, R_AEMPTY, R_LEVEL, R_VALID, R_UNDERFLOW);
        end
    endtask

    task automatic test_sync_latency();
        R_RST = 1'b1; G_wptr = 4'b0010;
        tick();
        vec_cnt++;
        if (R_EMPTY !== 1'b1) begin
            err_cnt++; $display("FAIL sync_lat_1: empty=%b want 1", R_EMPTY);
        end
        tick();
        vec_cnt++;
        if ({R_EMPTY, R_LEVEL, R_AEMPTY} !== {1'b0, 4'd3, 1'b0}) begin
            err_cnt++; $display("FAIL sync_lat_2: e=%b lvl=%0d ae=%b want 0 3 0", R_EMPTY, R_LEVEL, R_AEMPTY);
        end
    endtask

    task automatic test_drain();
        logic [2:0] exp_addr [3] = '{3'd1, 3'd2, 3'd3};
        logic [3:0] exp_lvl  [3] = '{4'd2, 4'd1, 4'd0};
        logic       exp_e    [3] = '{1'b0, 1'b0, 1'b1};
        vec_cnt++;
        if (R_addr !== 3'd0) begin
            err_cnt++; $display("FAIL drain_start: addr=%0d want 0", R_addr);
        end
        R_INC = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++;
            if ({R_addr, R_LEVEL, R_AEMPTY, R_EMPTY, R_VALID} !== {exp_addr[i], exp_lvl[i], 1'b1, exp_e[i], 1'b1}) begin
                err_cnt++;
                $display("FAIL drain_pop%0d: addr=%0d lvl=%0d ae=%b e=%b v=%b want %0d %0d 1 %b 1",
                         i, R_addr, R_LEVEL, R_AEMPTY, R_EMPTY, R_VALID, exp_addr[i], exp_lvl[i], exp_e[i]);
            end
        end
        tick();
        vec_cnt++;
        if ({R_UNDERFLOW, R_addr, R_VALID, R_LEVEL} !== {1'b1, 3'd3, 1'b0, 4'd0}) begin
            err_cnt++;
            $display("FAIL drain_underflow: uf=%b addr=%0d v=%b lvl=%0d want 1 3 0 0", R_UNDERFLOW, R_addr, R_VALID, R_LEVEL);
        end
        R_INC = 1'b0;
        tick();
        vec_cnt++;
        if ({R_UNDERFLOW, R_VALID} !== {1'b1, 1'b0}) begin
            err_cnt++; $display("FAIL uf_sticky: uf=%b v=%b want 1 0", R_UNDERFLOW, R_VALID);
        end
    endtask

    // Fill to DEPTH, drain fully twice so the read pointer passes binary 8 and 16.
    task automatic test_full_wrap();
        logic [3:0] gw [2] = '{4'b1100, 4'b0000};
        logic [3:0] gend [2] = '{4'b1100, 4'b0000};
        logic [3:0] rb;
        logic [3:0] lvl;
        R_RST = 1'b0; G_wptr = 4'b0000;
        tick();
        R_RST = 1'b1;
        for (int r = 0; r < 2; r++) begin
            G_wptr = gw[r];
            tick(); tick();
            vec_cnt++;
            if ({R_LEVEL, R_EMPTY, R_AEMPTY, R_UNDERFLOW} !== {4'd8, 1'b0, 1'b0, 1'b0}) begin
                err_cnt++;
                $display("FAIL full_r%0d: lvl=%0d e=%b ae=%b uf=%b want 8 0 0 0", r, R_LEVEL, R_EMPTY, R_AEMPTY, R_UNDERFLOW);
            end
            R_INC = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                tick();
                rb  = 4'(r * 8 + i);
                lvl = 4'(8 - i);
                vec_cnt++;
                if ({R_addr, G_rptr, R_LEVEL, R_AEMPTY, R_VALID} !== {rb[2:0], rb ^ (rb >> 1), lvl, (lvl <= 4'd2), 1'b1}) begin
                    err_cnt++;
                    $display("FAIL wrap_r%0d_pop%0d: addr=%0d rptr=%b lvl=%0d ae=%b v=%b want %0d %b %0d %b 1",
                             r, i, R_addr, G_rptr, R_LEVEL, R_AEMPTY, R_VALID, rb[2:0], rb ^ (rb >> 1), lvl, (lvl <= 4'd2));
                end
            end
            R_INC = 1'b0;
            vec_cnt++;
            if ({R_addr, G_rptr, R_EMPTY} !== {3'd0, gend[r], 1'b1}) begin
                err_cnt++;
                $display("FAIL wrap_end_r%0d: addr=%0d rptr=%b e=%b want 0 %b 1", r, R_addr, G_rptr, R_EMPTY, gend[r]);
            end
        end
    endtask

    task automatic test_uf_clear();
        R_INC = 1'b1; UF_CLR = 1'b1;
        tick();
        vec_cnt++;
        if (R_UNDERFLOW !== 1'b1) begin
            err_cnt++; $display("FAIL uf_set_wins: uf=%b want 1", R_UNDERFLOW);
        end
        R_INC = 1'b0;
        tick();
        vec_cnt++;
        if (R_UNDERFLOW !== 1'b0) begin
            err_cnt++; $display("FAIL uf_clear: uf=%b want 0", R_UNDERFLOW);
        end
        UF_CLR = 1'b0;
    endtask

    task automatic test_threshold();
        G_wptr = 4'b0111;
        tick(); tick();
        vec_cnt++;
        if ({R_LEVEL, R_AEMPTY} !== {4'd5, 1'b0}) begin
            err_cnt++; $display("FAIL level5: lvl=%0d ae=%b want 5 0", R_LEVEL, R_AEMPTY);
        end
        AE_THRESH = 4'd5;
        tick();
        vec_cnt++;
        if (R_AEMPTY !== 1'b1) begin
            err_cnt++; $display("FAIL thresh_eq: ae=%b want 1", R_AEMPTY);
        end
        AE_THRESH = 4'd4;
        tick();
        vec_cnt++;
        if (R_AEMPTY !== 1'b0) begin
            err_cnt++; $display("FAIL thresh_below: ae=%b want 0", R_AEMPTY);
        end
        AE_THRESH = 4'd2;
    endtask

    task automatic test_mid_reset();
        R_INC = 1'b1;
        tick();
        R_INC = 1'b0;
        vec_cnt++;
        if ({R_LEVEL, R_addr} !== {4'd4, 3'd1}) begin
            err_cnt++; $display("FAIL pre_reset_pop: lvl=%0d addr=%0d want 4 1", R_LEVEL, R_addr);
        end
        R_RST = 1'b0;
        tick();
        R_RST = 1'b1;
        vec_cnt++;
        if ({G_rptr, R_addr, R_EMPTY, R_AEMPTY, R_LEVEL, R_VALID, R_UNDERFLOW} !== {4'd0, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL mid_reset: rptr=%b addr=%0d e=%b ae=%b lvl=%0d v=%b uf=%b, want 0 0 1 1 0 0 0",
                     G_rptr, R_addr, R_EMPTY, R_AEMPTY, R_LEVEL, R_VALID, R_UNDERFLOW);
        end
        tick();
        vec_cnt++;
        if ({R_EMPTY, R_LEVEL} !== {1'b1, 4'd0}) begin
            err_cnt++; $display("FAIL post_reset_1: e=%b lvl=%0d want 1 0", R_EMPTY, R_LEVEL);
        end
        tick();
        vec_cnt++;
        if ({R_EMPTY, R_LEVEL, R_AEMPTY} !== {1'b0, 4'd5, 1'b0}) begin
            err_cnt++; $display("FAIL post_reset_2: e=%b lvl=%0d ae=%b want 0 5 0", R_EMPTY, R_LEVEL, R_AEMPTY);
        end
    endtask

    initial begin
        test_reset();
        test_sync_latency();
        test_drain();
        test_full_wrap();
        test_uf_clear();
        test_threshold();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
